// File: rtl/plate_locate.sv
// Blue-plate locator: binarises the YCbCr stream and reports one plate
// bounding box per frame, from row/column projections of the blue pixels.
module plate_locate #(
   parameter logic [7:0]    CB_MIN   = 8'd140,
   parameter logic [7:0]    CR_MAX   = 8'd120,
   parameter int            CW       = 11,
   parameter logic [CW-1:0] ROW_TH   = 11'd40,
   parameter logic [CW-1:0] MIN_ROWS = 11'd8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pre_frame_vsync,
   input  logic          pre_frame_hsync,
   input  logic          pre_frame_de,
   input  logic [7:0]    img_y,
   input  logic [7:0]    img_cb,
   input  logic [7:0]    img_cr,
   output logic          post_frame_vsync,
   output logic          post_frame_hsync,
   output logic          post_frame_de,
   output logic          post_img_bit,
   output logic [CW-1:0] plate_top,
   output logic [CW-1:0] plate_bottom,
   output logic [CW-1:0] plate_left,
   output logic [CW-1:0] plate_right,
   output logic          plate_found,
   output logic          plate_valid
);

   localparam logic [CW-1:0] CMAX = '1;

   logic          vsync_d, de_d, sof, eol, blue;
   logic          frame_started;
   logic [CW-1:0] x_cnt, y_cnt;
   logic [CW-1:0] row_cnt, row_xmin, row_xmax;
   logic [CW-1:0] row_cnt_n, row_xmin_n, row_xmax_n;
   logic          found, found_n;
   logic [CW-1:0] top, bottom, left, right;
   logic [CW-1:0] top_n, bottom_n, left_n, right_n;
   logic          line_ok, height_ok;
   logic [CW:0]   height;
   logic          unused_y;

   assign unused_y = ^img_y;

   assign sof  = pre_frame_vsync & ~vsync_d;
   assign eol  = de_d & ~pre_frame_de;
   assign blue = pre_frame_de & (img_cb > CB_MIN) & (img_cr < CR_MAX);

   // Line and frame accumulators as they stand after this clock's pixel/EOL,
   // so a SOF in the same clock closes the frame with the last line included.
   always_comb begin
      row_cnt_n  = row_cnt;
      row_xmin_n = row_xmin;
      row_xmax_n = row_xmax;
      if (blue) begin
         if (row_cnt != CMAX) row_cnt_n = row_cnt + 1'b1;
         if (row_cnt == '0 || x_cnt < row_xmin) row_xmin_n = x_cnt;
         if (row_cnt == '0 || x_cnt > row_xmax) row_xmax_n = x_cnt;
      end
      line_ok  = eol & (row_cnt_n >= ROW_TH);
      found_n  = found;
      top_n    = top;
      bottom_n = bottom;
      left_n   = left;
      right_n  = right;
      if (line_ok) begin
         if (!found) begin
            top_n   = y_cnt;
            left_n  = row_xmin_n;
            right_n = row_xmax_n;
         end else begin
            left_n  = (row_xmin_n < left)  ? row_xmin_n : left;
            right_n = (row_xmax_n > right) ? row_xmax_n : right;
         end
         bottom_n = y_cnt;
         found_n  = 1'b1;
      end
      height    = {1'b0, bottom_n} - {1'b0, top_n} + 1'b1;
      height_ok = height >= {1'b0, MIN_ROWS};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_d          <= 1'b0;
         de_d             <= 1'b0;
         post_frame_vsync <= 1'b0;
         post_frame_hsync <= 1'b0;
         post_frame_de    <= 1'b0;
         post_img_bit     <= 1'b0;
         x_cnt            <= '0;
         y_cnt            <= '0;
         row_cnt          <= '0;
         row_xmin         <= '0;
         row_xmax         <= '0;
      end else begin
         vsync_d          <= pre_frame_vsync;
         de_d             <= pre_frame_de;
         post_frame_vsync <= pre_frame_vsync;
         post_frame_hsync <= pre_frame_hsync;
         post_frame_de    <= pre_frame_de;
         post_img_bit     <= blue;
         if (eol)                              x_cnt <= '0;
         else if (pre_frame_de && x_cnt != CMAX) x_cnt <= x_cnt + 1'b1;
         if (sof)                              y_cnt <= '0;
         else if (eol && y_cnt != CMAX)        y_cnt <= y_cnt + 1'b1;
         if (eol) begin
            row_cnt  <= '0;
            row_xmin <= '0;
            row_xmax <= '0;
         end else begin
            row_cnt  <= row_cnt_n;
            row_xmin <= row_xmin_n;
            row_xmax <= row_xmax_n;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_started <= 1'b0;
         found         <= 1'b0;
         top           <= '0;
         bottom        <= '0;
         left          <= '0;
         right         <= '0;
         plate_top     <= '0;
         plate_bottom  <= '0;
         plate_left    <= '0;
         plate_right   <= '0;
         plate_found   <= 1'b0;
         plate_valid   <= 1'b0;
      end else begin
         plate_valid <= sof & frame_started;
         if (sof) begin
            if (frame_started) begin
               plate_found <= found_n & height_ok;
               if (found_n && height_ok) begin
                  plate_top    <= top_n;
                  plate_bottom <= bottom_n;
                  plate_left   <= left_n;
                  plate_right  <= right_n;
               end
            end
            frame_started <= 1'b1;
            found         <= 1'b0;
            top           <= '0;
            bottom        <= '0;
            left          <= '0;
            right         <= '0;
         end else begin
            found  <= found_n;
            top    <= top_n;
            bottom <= bottom_n;
            left   <= left_n;
            right  <= right_n;
         end
      end
   end

endmodule

// File: tb/tb_plate_locate.sv
// Scoreboard bench for plate_locate on scaled-down frames (80 px x 24 lines).
module tb_plate_locate;

   localparam int W = 80;

   typedef struct packed {
      logic        found;
      logic [10:0] top;
      logic [10:0] bottom;
      logic [10:0] left;
      logic [10:0] right;
   } box_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        vsync = 1'b0, hsync = 1'b0, de = 1'b0;
   logic [7:0]  y = 8'd0, cb = 8'd0, cr = 8'd0;
   logic        post_vsync, post_hsync, post_de, post_bit;
   logic [10:0] p_top, p_bottom, p_left, p_right;
   logic        p_found, p_valid;

   int   n_vec = 0;
   int   n_err = 0;
   bit   px_q[$];
   box_t box_q[$];

   // boundary pixels placed at x=0..4 of one line
   logic [7:0] bt_cb [5] = '{8'd140, 8'd200, 8'd141, 8'd141, 8'd255};
   logic [7:0] bt_cr [5] = '{8'd90,  8'd120, 8'd119, 8'd120, 8'd0};
   bit         bt_exp[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

   localparam box_t BOX_A    = '{1'b1, 11'd5, 11'd14, 11'd10, 11'd59};
   localparam box_t BOX_HOLD = '{1'b0, 11'd5, 11'd14, 11'd10, 11'd59};

   plate_locate dut (
      .clk(clk), .rst_n(rst_n),
      .pre_frame_vsync(vsync), .pre_frame_hsync(hsync), .pre_frame_de(de),
      .img_y(y), .img_cb(cb), .img_cr(cr),
      .post_frame_vsync(post_vsync), .post_frame_hsync(post_hsync),
      .post_frame_de(post_de), .post_img_bit(post_bit),
      .plate_top(p_top), .plate_bottom(p_bottom),
      .plate_left(p_left), .plate_right(p_right),
      .plate_found(p_found), .plate_valid(p_valid)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pops expectations whenever the DUT presents pixel or box output.
   initial begin
      forever begin
         @(negedge clk);
         if (post_de) begin
            if (px_q.size() == 0) check("pixel_unexpected", 64'd1, 64'd0);
            else check("post_img_bit", {63'd0, post_bit}, {63'd0, px_q.pop_front()});
         end
         if (p_valid) begin
            if (box_q.size() == 0) check("plate_valid_unexpected", 64'd1, 64'd0);
            else check("plate_box", {9'd0, p_found, p_top, p_bottom, p_left, p_right},
                       {9'd0, box_q.pop_front()});
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic do_sof(input bit pulse, input box_t e);
      @(negedge clk);
      if (pulse) box_q.push_back(e);
      vsync = 1'b1;
      repeat (3) @(negedge clk);
      vsync = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   // nl lines; blue rect x0..x1 / y0..y1; boundary pattern on line bline;
   // merge: the last line's de fall coincides with the vsync rise.
   task automatic do_lines(input int nl, input int x0, input int x1, input int y0,
                           input int y1, input int bline, input bit merge);
      for (int ln = 0; ln < nl; ln++) begin
         for (int x = 0; x < W; x++) begin
            @(negedge clk);
            de = 1'b1;
            hsync = 1'b1;
            if (ln == bline && x < 5) begin
               cb = bt_cb[x]; cr = bt_cr[x]; px_q.push_back(bt_exp[x]);
            end else if (ln >= y0 && ln <= y1 && x >= x0 && x <= x1) begin
               cb = 8'd200; cr = 8'd90; px_q.push_back(1'b1);
            end else begin
               cb = 8'd128; cr = 8'd128; px_q.push_back(1'b0);
            end
         end
         @(negedge clk);
         de = 1'b0; hsync = 1'b0; cb = 8'd0; cr = 8'd0;
         if (merge && ln == nl - 1) vsync = 1'b1;
         repeat (3) @(negedge clk);
      end
      if (merge) begin
         vsync = 1'b0;
         repeat (3) @(negedge clk);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_post"}, {60'd0, post_vsync, post_hsync, post_de, post_bit}, 64'd0);
      check({tag, "_box"}, {20'd0, p_top, p_bottom, p_left, p_right}, 64'd0);
      check({tag, "_flags"}, {62'd0, p_found, p_valid}, 64'd0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // first SOF opens a frame silently; then two full plate frames
      do_sof(1'b0, BOX_A);
      do_lines(24, 10, 59, 5, 14, -1, 1'b0);
      do_sof(1'b1, BOX_A);
      do_lines(24, 10, 59, 5, 14, -1, 1'b0);
      do_sof(1'b1, BOX_A);

      // 30 px wide: no line reaches the row threshold
      do_lines(24, 10, 39, 5, 14, -1, 1'b0);
      do_sof(1'b1, BOX_HOLD);

      // 5 lines tall: below minimum height; plus boundary pixels on line 20
      do_lines(24, 10, 59, 5, 9, 20, 1'b0);
      do_sof(1'b1, BOX_HOLD);

      // last blue line (14) ends in the same clock as the vsync rise
      box_q.push_back(BOX_A);
      do_lines(15, 10, 59, 5, 14, -1, 1'b1);

      // reset mid-frame during horizontal blanking
      do_lines(8, 10, 59, 5, 14, -1, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check_reset_outputs("midreset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      do_sof(1'b0, BOX_A);
      do_lines(24, 10, 59, 5, 14, -1, 1'b0);
      do_sof(1'b1, BOX_A);

      repeat (10) @(negedge clk);
      check("pixel_queue_drained", 64'(px_q.size()), 64'd0);
      check("box_queue_drained", 64'(box_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
